// File: rtl/l15_req_arbiter.sv
// Shares the single L1.5 request/response port between the IFU and the LSU.
// One transaction in flight at a time; the response is routed back to the requester that issued it.
`timescale 1ns/1ps
module l15_req_arbiter #(
  parameter logic [5:0] IFILL_RQ  = 6'b010000,
  parameter logic [3:0] LOAD_RET  = 4'b0000,
  parameter logic [3:0] ST_ACK    = 4'b0100,
  parameter logic [3:0] IFILL_RET = 4'b0001
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        ifu_req_val,
  input  logic [31:0] ifu_req_addr,
  output logic        ifu_req_rdy,
  output logic        ifu_resp_val,
  output logic [31:0] ifu_resp_data,
  input  logic        lsu_req_val,
  input  logic [5:0]  lsu_req_rqtype,
  input  logic [2:0]  lsu_req_size,
  input  logic [31:0] lsu_req_addr,
  input  logic [31:0] lsu_req_data,
  output logic        lsu_req_rdy,
  output logic        lsu_resp_val,
  output logic [31:0] lsu_resp_data,
  output logic [5:0]  core_l15_rqtype,
  output logic [2:0]  core_l15_size,
  output logic [31:0] core_l15_address,
  output logic [31:0] core_l15_data,
  output logic        core_l15_val,
  input  logic        l15_core_header_ack,
  input  logic        l15_core_val,
  input  logic [3:0]  l15_core_returntype,
  input  logic [31:0] l15_core_data_0,
  output logic        core_l15_req_ack
);

  // Handshake: a request transfers on the rising edge where val && rdy; rdy is
  // only offered in IDLE, so a requester seeing rdy=0 keeps val and its fields stable.

  localparam logic [5:0] RQ_LOAD = 6'b000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       owner_ifu;
  logic       prio_ifu;
  logic       grant_ifu;
  logic       grant_lsu;
  logic       accept;
  logic       contested;
  logic       rq_is_load;
  logic [3:0] exp_ret;
  logic       resp_match;

  assign grant_ifu  = ifu_req_val && (!lsu_req_val || prio_ifu);
  assign grant_lsu  = lsu_req_val && (!ifu_req_val || !prio_ifu);
  assign accept     = (state == IDLE) && (grant_ifu || grant_lsu);
  assign contested  = accept && ifu_req_val && lsu_req_val;

  // The latched rqtype tells a load from a store once the request has been sent.
  assign rq_is_load = (core_l15_rqtype == RQ_LOAD);
  assign exp_ret    = owner_ifu ? IFILL_RET : (rq_is_load ? LOAD_RET : ST_ACK);
  assign resp_match = (state == WAIT) && l15_core_val && (l15_core_returntype == exp_ret);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SEND;
      SEND:    if (l15_core_header_ack) state_nxt = WAIT;
      WAIT:    if (resp_match) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ifu_req_rdy  = 1'b0;
    lsu_req_rdy  = 1'b0;
    core_l15_val = 1'b0;
    case (state)
      IDLE: begin
        ifu_req_rdy = grant_ifu;
        lsu_req_rdy = grant_lsu;
      end
      SEND:    core_l15_val = 1'b1;
      default: ;
    endcase
  end

  // Request fields are captured at the grant and held untouched through SEND.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      owner_ifu        <= 1'b0;
      prio_ifu         <= 1'b0;
      core_l15_rqtype  <= '0;
      core_l15_size    <= '0;
      core_l15_address <= '0;
      core_l15_data    <= '0;
    end else begin
      if (contested) prio_ifu <= !prio_ifu;
      if (accept) begin
        owner_ifu <= grant_ifu;
        if (grant_ifu) begin
          core_l15_rqtype  <= IFILL_RQ;
          core_l15_size    <= 3'b010;
          core_l15_address <= ifu_req_addr;
          core_l15_data    <= '0;
        end else begin
          core_l15_rqtype  <= lsu_req_rqtype;
          core_l15_size    <= lsu_req_size;
          core_l15_address <= lsu_req_addr;
          core_l15_data    <= lsu_req_data;
        end
      end
    end
  end

  // Every response is acked; only a matching one in WAIT reaches the owner.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      core_l15_req_ack <= 1'b0;
      ifu_resp_val     <= 1'b0;
      lsu_resp_val     <= 1'b0;
      ifu_resp_data    <= '0;
      lsu_resp_data    <= '0;
    end else begin
      core_l15_req_ack <= l15_core_val;
      ifu_resp_val     <= resp_match && owner_ifu;
      lsu_resp_val     <= resp_match && !owner_ifu;
      ifu_resp_data    <= (resp_match && owner_ifu) ? l15_core_data_0 : '0;
      lsu_resp_data    <= (resp_match && !owner_ifu && rq_is_load) ? l15_core_data_0 : '0;
    end
  end

endmodule

// File: tb/tb_l15_req_arbiter.sv
// Bench for l15_req_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of arbitration and response routing.
`timescale 1ns/1ps
module tb_l15_req_arbiter;

  localparam logic [5:0] IFILL_RQ  = 6'b010000;
  localparam logic [5:0] RQ_LOAD   = 6'b000000;
  localparam logic [5:0] RQ_STORE  = 6'b000001;
  localparam logic [3:0] LOAD_RET  = 4'b0000;
  localparam logic [3:0] ST_ACK    = 4'b0100;
  localparam logic [3:0] IFILL_RET = 4'b0001;
  localparam logic [3:0] INV_RET   = 4'b0011;

  logic        clk;
  logic        nrst;
  logic        ifu_req_val;
  logic [31:0] ifu_req_addr;
  logic        ifu_req_rdy;
  logic        ifu_resp_val;
  logic [31:0] ifu_resp_data;
  logic        lsu_req_val;
  logic [5:0]  lsu_req_rqtype;
  logic [2:0]  lsu_req_size;
  logic [31:0] lsu_req_addr;
  logic [31:0] lsu_req_data;
  logic        lsu_req_rdy;
  logic        lsu_resp_val;
  logic [31:0] lsu_resp_data;
  logic [5:0]  core_l15_rqtype;
  logic [2:0]  core_l15_size;
  logic [31:0] core_l15_address;
  logic [31:0] core_l15_data;
  logic        core_l15_val;
  logic        l15_core_header_ack;
  logic        l15_core_val;
  logic [3:0]  l15_core_returntype;
  logic [31:0] l15_core_data_0;
  logic        core_l15_req_ack;

  l15_req_arbiter dut (
    .clk(clk), .nrst(nrst),
    .ifu_req_val(ifu_req_val), .ifu_req_addr(ifu_req_addr), .ifu_req_rdy(ifu_req_rdy),
    .ifu_resp_val(ifu_resp_val), .ifu_resp_data(ifu_resp_data),
    .lsu_req_val(lsu_req_val), .lsu_req_rqtype(lsu_req_rqtype), .lsu_req_size(lsu_req_size),
    .lsu_req_addr(lsu_req_addr), .lsu_req_data(lsu_req_data), .lsu_req_rdy(lsu_req_rdy),
    .lsu_resp_val(lsu_resp_val), .lsu_resp_data(lsu_resp_data),
    .core_l15_rqtype(core_l15_rqtype), .core_l15_size(core_l15_size),
    .core_l15_address(core_l15_address), .core_l15_data(core_l15_data), .core_l15_val(core_l15_val),
    .l15_core_header_ack(l15_core_header_ack), .l15_core_val(l15_core_val),
    .l15_core_returntype(l15_core_returntype), .l15_core_data_0(l15_core_data_0),
    .core_l15_req_ack(core_l15_req_ack)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Event counters sampled on the falling edge, away from the register updates.
  int ack_cnt, ifu_resp_cnt, lsu_resp_cnt, val_cnt, both_cnt;
  always @(negedge clk) begin
    if (core_l15_req_ack) ack_cnt++;
    if (ifu_resp_val) ifu_resp_cnt++;
    if (lsu_resp_val) lsu_resp_cnt++;
    if (core_l15_val) val_cnt++;
    if (ifu_resp_val && lsu_resp_val) both_cnt++;
  end

  // Reference model: pending requests in their L1.5 form, round-robin pointer, expected responses.
  typedef struct packed {
    logic [5:0]  rqtype;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  req_t        ifu_req;
  req_t        lsu_req;
  bit          ifu_pend;
  bit          lsu_pend;
  bit          m_prio_ifu;
  logic [31:0] exp_q[$];

  task automatic drive_reqs();
    ifu_req_val    = ifu_pend;
    ifu_req_addr   = ifu_req.addr;
    lsu_req_val    = lsu_pend;
    lsu_req_rqtype = lsu_req.rqtype;
    lsu_req_size   = lsu_req.size;
    lsu_req_addr   = lsu_req.addr;
    lsu_req_data   = lsu_req.data;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    ifu_pend = 1'b0;
    lsu_pend = 1'b0;
    m_prio_ifu = 1'b0;
    ifu_req = '0;
    lsu_req = '0;
    exp_q.delete();
    drive_reqs();
    l15_core_val = 1'b0;
    l15_core_header_ack = 1'b0;
    l15_core_returntype = '0;
    l15_core_data_0 = '0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_val"}, core_l15_val, 0);
    check({tag, "_rqtype"}, core_l15_rqtype, 0);
    check({tag, "_size"}, core_l15_size, 0);
    check({tag, "_addr"}, core_l15_address, 0);
    check({tag, "_data"}, core_l15_data, 0);
    check({tag, "_req_ack"}, core_l15_req_ack, 0);
    check({tag, "_resp_val"}, {ifu_resp_val, lsu_resp_val}, 0);
    check({tag, "_ifu_resp_data"}, ifu_resp_data, 0);
    check({tag, "_lsu_resp_data"}, lsu_resp_data, 0);
    check({tag, "_rdy"}, {ifu_req_rdy, lsu_req_rdy}, 0);
  endtask

  // One full transaction starting in IDLE; ends on the cycle the response appears.
  task automatic do_txn(input bit new_ifu, input bit new_lsu, input req_t lsu_new,
                        input logic [31:0] ifu_addr, input int send_wait, input bit spur,
                        input logic [3:0] spur_rt, input int n_inv, input logic [3:0] inv_rt_in,
                        input logic [31:0] rdata);
    bit         win_ifu;
    req_t       w;
    logic [3:0] ret;
    logic [3:0] inv_rt;
    int         a0, i0, l0, v0;
    if (new_ifu && !ifu_pend) begin
      ifu_pend = 1'b1;
      ifu_req.rqtype = IFILL_RQ;
      ifu_req.size = 3'b010;
      ifu_req.addr = ifu_addr;
      ifu_req.data = 32'h0;
    end
    if (new_lsu && !lsu_pend) begin
      lsu_pend = 1'b1;
      lsu_req = lsu_new;
    end
    drive_reqs();
    l15_core_val = 1'b0;
    l15_core_header_ack = 1'b0;
    #1;
    if (ifu_pend && lsu_pend) begin
      win_ifu = m_prio_ifu;
      m_prio_ifu = !m_prio_ifu;
    end else begin
      win_ifu = ifu_pend;
    end
    check("grant_ifu_rdy", ifu_req_rdy, win_ifu);
    check("grant_lsu_rdy", lsu_req_rdy, !win_ifu && lsu_pend);
    w = win_ifu ? ifu_req : lsu_req;
    if (win_ifu) ifu_pend = 1'b0;
    else lsu_pend = 1'b0;
    ret = win_ifu ? IFILL_RET : ((w.rqtype == RQ_LOAD) ? LOAD_RET : ST_ACK);
    inv_rt = (inv_rt_in == ret) ? INV_RET : inv_rt_in;
    exp_q.push_back((win_ifu || w.rqtype == RQ_LOAD) ? rdata : 32'h0);
    a0 = ack_cnt; i0 = ifu_resp_cnt; l0 = lsu_resp_cnt; v0 = val_cnt;
    for (int c = 0; c <= send_wait; c++) begin
      @(negedge clk);
      drive_reqs();
      l15_core_header_ack = (c == send_wait);
      l15_core_val = spur && (c == 0);
      l15_core_returntype = spur_rt;
      l15_core_data_0 = $urandom;
      #1;
      check("send_val", core_l15_val, 1);
      check("send_rqtype", core_l15_rqtype, w.rqtype);
      check("send_size", core_l15_size, w.size);
      check("send_addr", core_l15_address, w.addr);
      check("send_data", core_l15_data, w.data);
      check("send_rdy", {ifu_req_rdy, lsu_req_rdy}, 0);
    end
    for (int k = 0; k < n_inv; k++) begin
      @(negedge clk);
      l15_core_header_ack = 1'b0;
      l15_core_val = 1'b1;
      l15_core_returntype = inv_rt;
      l15_core_data_0 = $urandom;
      #1;
      check("wait_val", core_l15_val, 0);
      check("wait_rdy", {ifu_req_rdy, lsu_req_rdy}, 0);
    end
    @(negedge clk);
    l15_core_header_ack = 1'b0;
    l15_core_val = 1'b1;
    l15_core_returntype = ret;
    l15_core_data_0 = rdata;
    #1;
    check("resp_cycle_val", core_l15_val, 0);
    @(negedge clk);
    l15_core_val = 1'b0;
    l15_core_data_0 = $urandom;
    #1;
    check("ifu_resp_val", ifu_resp_val, win_ifu);
    check("lsu_resp_val", lsu_resp_val, !win_ifu);
    if (win_ifu) check("ifu_resp_data", ifu_resp_data, exp_q.pop_front());
    else check("lsu_resp_data", lsu_resp_data, exp_q.pop_front());
    check("req_ack_count", ack_cnt - a0, n_inv + int'(spur) + 1);
    check("ifu_resp_count", ifu_resp_cnt - i0, win_ifu);
    check("lsu_resp_count", lsu_resp_cnt - l0, !win_ifu);
    check("send_cycles", val_cnt - v0, send_wait + 1);
  endtask

  initial begin
    req_t r;
    int   a0, i0, l0;
    checks = 0;
    failures = 0;
    ack_cnt = 0; ifu_resp_cnt = 0; lsu_resp_cnt = 0; val_cnt = 0; both_cnt = 0;

    nrst = 1'b0;
    ifu_pend = 1'b0;
    lsu_pend = 1'b0;
    ifu_req = '0;
    lsu_req = '0;
    drive_reqs();
    l15_core_val = 1'b0;
    l15_core_header_ack = 1'b0;
    l15_core_returntype = '0;
    l15_core_data_0 = '0;
    #1;
    check_all_zero("reset");
    do_reset();

    // Single LSU load, header ack on the second SEND cycle.
    r.rqtype = RQ_LOAD; r.size = 3'b011; r.addr = 32'h80; r.data = 32'h0;
    do_txn(0, 1, r, 32'h0, 1, 0, 4'h0, 0, INV_RET, 32'hDEADBEEF);

    // Contested from reset: LSU, IFU, LSU, IFU, then drain the leftover LSU.
    do_reset();
    for (int n = 0; n < 4; n++) begin
      r.rqtype = n[0] ? RQ_STORE : RQ_LOAD; r.size = 3'(n); r.addr = 32'h1000 + 32'(n * 64);
      r.data = $urandom;
      do_txn(1, 1, r, 32'h2000 + 32'(n * 64), n % 2, 0, 4'h0, 0, INV_RET, $urandom);
    end
    do_txn(0, 0, r, 32'h0, 0, 0, 4'h0, 0, INV_RET, $urandom);

    // Store: ST_ACK returns zero data even though data_0 is nonzero.
    r.rqtype = RQ_STORE; r.size = 3'b010; r.addr = 32'h44; r.data = 32'h12345678;
    do_txn(0, 1, r, 32'h0, 2, 0, 4'h0, 0, INV_RET, 32'h55AA55AA);

    // IFU fill with an invalidation in between.
    do_txn(1, 0, r, 32'h400, 0, 0, 4'h0, 1, INV_RET, 32'hCAFEF00D);

    // Reset in the middle of SEND.
    r.rqtype = RQ_STORE; r.size = 3'b001; r.addr = 32'h40; r.data = 32'hA5A5A5A5;
    lsu_req = r;
    lsu_pend = 1'b1;
    drive_reqs();
    #1;
    check("pre_reset_grant", lsu_req_rdy, 1);
    lsu_pend = 1'b0;
    @(negedge clk);
    drive_reqs();
    #1;
    check("pre_reset_send", core_l15_val, 1);
    nrst = 1'b0;
    #1;
    check_all_zero("mid_send_reset");
    @(negedge clk);
    nrst = 1'b1;
    m_prio_ifu = 1'b0;
    exp_q.delete();
    r.rqtype = RQ_LOAD; r.size = 3'b010; r.addr = 32'h300; r.data = 32'h0;
    do_txn(1, 1, r, 32'h600, 0, 0, 4'h0, 0, INV_RET, 32'h0BADF00D);
    do_txn(0, 0, r, 32'h0, 0, 0, 4'h0, 0, INV_RET, 32'h13572468);

    // Response while IDLE is acked and dropped.
    a0 = ack_cnt; i0 = ifu_resp_cnt; l0 = lsu_resp_cnt;
    l15_core_val = 1'b1;
    l15_core_returntype = LOAD_RET;
    l15_core_data_0 = 32'h77777777;
    @(negedge clk);
    l15_core_val = 1'b0;
    #1;
    check("idle_resp_ack", core_l15_req_ack, 1);
    @(negedge clk);
    #1;
    check("idle_resp_ack_pulse", core_l15_req_ack, 0);
    check("idle_resp_ack_count", ack_cnt - a0, 1);
    check("idle_resp_no_resp", (ifu_resp_cnt - i0) + (lsu_resp_cnt - l0), 0);
    r.rqtype = RQ_LOAD; r.size = 3'b000; r.addr = 32'h900; r.data = 32'h0;
    do_txn(0, 1, r, 32'h0, 0, 0, 4'h0, 0, INV_RET, 32'h24681357);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      bit ni, nl;
      ni = 1'($urandom_range(0, 1));
      nl = 1'($urandom_range(0, 1));
      if (!ni && !nl && !ifu_pend && !lsu_pend) nl = 1'b1;
      r.rqtype = $urandom_range(0, 1) ? RQ_STORE : RQ_LOAD;
      r.size = 3'($urandom_range(0, 7));
      r.addr = $urandom;
      r.data = $urandom;
      do_txn(ni, nl, r, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), $urandom_range(0, 2), 4'($urandom_range(0, 15)),
             $urandom);
    end

    check("both_resp_same_cycle", both_cnt, 0);
    check("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/l15_req_arbiter.md
Name: l15_req_arbiter

Overview:
- Sequences and shares the single OpenPiton L1.5 request/response port between two requesters: the instruction-fetch unit (IFU) and the load/store path of the execute stage (LSU).
- Allows exactly one outstanding transaction at a time.
- Holds each request until the L1.5 header acknowledge, then waits for the matching return and routes it back to the requester that issued it.

Parameters:
- IFILL_RQ, 6'b010000, rqtype driven for IFU requests.
- LOAD_RET, 4'b0000, returntype completing an LSU load.
- ST_ACK, 4'b0100, returntype completing an LSU store.
- IFILL_RET, 4'b0001, returntype completing an IFU fill.

Ports:
- clk  in  1  clock.
- nrst  in  1  reset; nrst asynchronous, active-low; clock clk.
- ifu_req_val  in  1  IFU request valid.
- ifu_req_addr  in  32  IFU fetch address.
- ifu_req_rdy  out  1  IFU request accepted this cycle.
- ifu_resp_val  out  1  IFU response valid, 1-cycle pulse.
- ifu_resp_data  out  32  IFU response data.
- lsu_req_val  in  1  LSU request valid.
- lsu_req_rqtype  in  6  LSU rqtype: load 6'b000000, store 6'b000001.
- lsu_req_size  in  3  LSU access size.
- lsu_req_addr  in  32  LSU address.
- lsu_req_data  in  32  LSU store data.
- lsu_req_rdy  out  1  LSU request accepted this cycle.
- lsu_resp_val  out  1  LSU response valid, 1-cycle pulse.
- lsu_resp_data  out  32  LSU load data; 0 for store acknowledges.
- core_l15_rqtype  out  6  L1.5 request type.
- core_l15_size  out  3  L1.5 request size.
- core_l15_address  out  32  L1.5 request address.
- core_l15_data  out  32  L1.5 store data.
- core_l15_val  out  1  L1.5 request valid.
- l15_core_header_ack  in  1  L1.5 has taken the request.
- l15_core_val  in  1  L1.5 response valid.
- l15_core_returntype  in  4  L1.5 response type.
- l15_core_data_0  in  32  L1.5 response data.
- core_l15_req_ack  out  1  response consumed, 1-cycle pulse.

Behaviour:
- Reset:
  - State IDLE; owner=LSU; priority pointer favours LSU.
  - All request fields, core_l15_val, both resp_val, both resp_data, core_l15_req_ack = 0.
  - Any in-flight transaction is abandoned.
- FSM states: IDLE, SEND, WAIT.
- IDLE:
  - rdy outputs are combinational and asserted only in IDLE.
  - If exactly one requester is valid, that requester gets rdy=1.
  - If both are valid, the requester named by the priority pointer wins and the pointer then toggles (round-robin).
  - On transfer (val&&rdy), the winner's fields are latched:
    - IFU: rqtype=IFILL_RQ, size=3'b010, data=0.
    - LSU: the supplied fields.
  - Owner is recorded; next state is SEND.
  - The pointer changes only on a contested grant.
- SEND:
  - core_l15_val=1 with the latched fields held stable every cycle.
  - On a cycle with l15_core_header_ack=1, next state is WAIT and val drops the following cycle.
- WAIT:
  - core_l15_val=0.
  - On l15_core_val=1, core_l15_req_ack pulses the next cycle (registered) for every response, matching or not.
  - Matching returntype completes the transaction:
    - owner IFU: IFILL_RET.
    - owner LSU: LOAD_RET if the latched rqtype is load, ST_ACK if store.
  - On a matching response the next cycle has:
    - owner resp_val=1.
    - resp_data = l15_core_data_0 (0 for ST_ACK).
    - state IDLE.
  - A non-matching returntype (e.g. invalidation) is acked and dropped; state stays WAIT.
- l15_core_val in IDLE or SEND: acked and dropped; no resp_val; no state change.
- resp_val must never be asserted for the non-owner.
- At most one resp_val is high per cycle.
- Minimum latency, request to response: accept (cycle 0), SEND (cycle 1), header_ack at cycle 1, WAIT (cycle 2), resp at cycle 2, resp_val at cycle 3.
- Requests arriving outside IDLE see rdy=0 and must hold val.

Test Plan:
- Single LSU load, addr 0x80, header_ack after 2 SEND cycles, response LOAD_RET data 0xDEADBEEF:
  - core_l15_val high exactly 2 cycles with rqtype 0, addr 0x80.
  - lsu_resp_val pulses once with 0xDEADBEEF.
  - req_ack pulses once.
  - ifu_resp_val stays 0.
- IFU and LSU valid simultaneously from reset, repeated 4 times: grants alternate LSU, IFU, LSU, IFU; each response is routed only to its owner.
- LSU store data 0x12345678, response ST_ACK:
  - core_l15_data=0x12345678 held through SEND.
  - lsu_resp_val=1 with lsu_resp_data=0.
- During WAIT for an IFU fill, an invalidation (returntype 4'b0011) arrives, then IFILL_RET 0xCAFEF00D:
  - Two req_ack pulses.
  - Single ifu_resp_val with 0xCAFEF00D.
- nrst asserted mid-SEND: core_l15_val and all outputs go 0 immediately; after release, state is IDLE and a new LSU request is granted on the first cycle.
- Response arriving while IDLE: req_ack pulses; no resp_val; next request proceeds normally.
